// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves EX-stage branches/jumps, owns the fetch PC and drives the IF/ID flush window.
// Rev 1.0
`default_nettype none

module branch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic        jump_i,
  input  logic [2:0]  funct3_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  input  logic [31:0] target_i,
  output logic        br_unsign_o,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        taken_o,
  output logic        illegal_o,
  output logic [15:0] br_cnt_o,
  output logic [15:0] taken_cnt_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t     state;
  logic [2:0] flush_cnt;
  logic       take_cond;
  logic       funct_ok;
  logic       resolve;

  // funct3 010/011 are reserved encodings and never redirect
  always_comb begin
    take_cond = 1'b0;
    case (funct3_i)
      3'b000:          take_cond = br_equal_i;
      3'b001:          take_cond = !br_equal_i;
      3'b100, 3'b110:  take_cond = br_less_i;
      3'b101, 3'b111:  take_cond = !br_less_i;
      default:         take_cond = 1'b0;
    endcase
  end

  assign funct_ok    = (funct3_i[2:1] != 2'b01);
  assign br_unsign_o = funct3_i[1];
  assign resolve     = (state == RUN) && !stall_i && (jump_i || (br_valid_i && take_cond));
  assign flush_o     = (state == FLUSH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= RUN;
      flush_cnt   <= 3'd0;
      pc_o        <= RESET_PC;
      taken_o     <= 1'b0;
      illegal_o   <= 1'b0;
      br_cnt_o    <= 16'h0000;
      taken_cnt_o <= 16'h0000;
    end else begin
      taken_o   <= 1'b0;
      illegal_o <= 1'b0;
      if (!stall_i) begin
        case (state)
          RUN: begin
            // a branch is counted even when a simultaneous jump wins the redirect
            if (br_valid_i && funct_ok && (br_cnt_o != 16'hFFFF))
              br_cnt_o <= br_cnt_o + 16'd1;
            if (br_valid_i && !funct_ok)
              illegal_o <= 1'b1;
            if (resolve) begin
              pc_o      <= {target_i[31:2], 2'b00};
              taken_o   <= 1'b1;
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
              if (taken_cnt_o != 16'hFFFF)
                taken_cnt_o <= taken_cnt_o + 16'd1;
            end else begin
              pc_o <= pc_o + 32'd4;
            end
          end
          FLUSH: begin
            pc_o      <= pc_o + 32'd4;
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt == 3'd1)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scenario tasks plus a per-cycle scoreboard for branch_ctrl.
// Rev 1.0
`default_nettype none

module tb_branch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FC       = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        stall_i = 1'b0, br_valid_i = 1'b0, jump_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic        br_less_i = 1'b0, br_equal_i = 1'b0;
  logic [31:0] target_i = 32'h0;
  logic        br_unsign_o, flush_o, taken_o, illegal_o;
  logic [31:0] pc_o;
  logic [15:0] br_cnt_o, taken_cnt_o;

  branch_ctrl #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .br_valid_i(br_valid_i),
    .jump_i(jump_i), .funct3_i(funct3_i), .br_less_i(br_less_i), .br_equal_i(br_equal_i),
    .target_i(target_i), .br_unsign_o(br_unsign_o), .pc_o(pc_o), .flush_o(flush_o),
    .taken_o(taken_o), .illegal_o(illegal_o), .br_cnt_o(br_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic        flush;
    logic        taken;
    logic        illegal;
    logic [15:0] brc;
    logic [15:0] tkc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e, mon_a;
  int          n_checks = 0;
  int          n_fail = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_fl;
  int          m_fc;
  logic [15:0] m_brc, m_tkc;

  // scoreboard consumer: one expected entry per clocked step
  always @(posedge clk_i) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a = {pc_o, flush_o, taken_o, illegal_o, br_cnt_o, taken_cnt_o};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard got pc=%h fl=%b tk=%b il=%b brc=%0d tkc=%0d exp pc=%h fl=%b tk=%b il=%b brc=%0d tkc=%0d",
                 mon_a.pc, mon_a.flush, mon_a.taken, mon_a.illegal, mon_a.brc, mon_a.tkc,
                 mon_e.pc, mon_e.flush, mon_e.taken, mon_e.illegal, mon_e.brc, mon_e.tkc);
      end
    end
  end

  function automatic logic cond_of(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      3'b000: return eq;
      3'b001: return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic st, input logic bv, input logic jp, input logic [2:0] f3,
                      input logic lt, input logic eq, input logic [31:0] tg);
    exp_t e;
    logic ok;
    stall_i = st; br_valid_i = bv; jump_i = jp; funct3_i = f3;
    br_less_i = lt; br_equal_i = eq; target_i = tg;
    e.taken = 1'b0;
    e.illegal = 1'b0;
    if (!st) begin
      if (!m_fl) begin
        ok = !(f3 == 3'b010 || f3 == 3'b011);
        if (bv && ok && m_brc != 16'hFFFF) m_brc = m_brc + 16'd1;
        if (bv && !ok) e.illegal = 1'b1;
        if (jp || (bv && cond_of(f3, lt, eq))) begin
          m_pc = {tg[31:2], 2'b00};
          e.taken = 1'b1;
          m_fl = 1'b1;
          m_fc = FC;
          if (m_tkc != 16'hFFFF) m_tkc = m_tkc + 16'd1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else begin
        m_pc = m_pc + 32'd4;
        m_fc = m_fc - 1;
        if (m_fc == 0) m_fl = 1'b0;
      end
    end
    e.pc = m_pc; e.flush = m_fl; e.brc = m_brc; e.tkc = m_tkc;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic model_reset();
    #2;
    rst_ni = 1'b0;
    sb_q.delete();
    m_pc = RESET_PC; m_fl = 1'b0; m_fc = 0; m_brc = 16'h0; m_tkc = 16'h0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    n_checks++; if (pc_o !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_o, RESET_PC); end
    n_checks++; if ({flush_o, taken_o, illegal_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {flush_o, taken_o, illegal_o}); end
    n_checks++; if ({br_cnt_o, taken_cnt_o} !== 32'h0) begin n_fail++; $display("FAIL reset_cnts got=%h exp=0", {br_cnt_o, taken_cnt_o}); end
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idle();
      n_checks++; if (pc_o !== 32'(4 * i)) begin n_fail++; $display("FAIL idle_pc%0d got=%h exp=%h", i, pc_o, 32'(4 * i)); end
      n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL idle_flush%0d got=%b exp=0", i, flush_o); end
    end
  endtask

  task automatic test_taken_branch();
    idle();
    n_checks++; if (pc_o !== 32'h10) begin n_fail++; $display("FAIL pre_branch_pc got=%h exp=00000010", pc_o); end
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h103);
    n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("FAIL beq_pc got=%h exp=00000100", pc_o); end
    n_checks++; if ({taken_o, flush_o} !== 2'b11) begin n_fail++; $display("FAIL beq_taken_flush got=%b exp=11", {taken_o, flush_o}); end
    n_checks++; if ({br_cnt_o, taken_cnt_o} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL beq_cnts got=%0d/%0d exp=1/1", br_cnt_o, taken_cnt_o); end
    idle();
    n_checks++; if ({pc_o, flush_o, taken_o} !== {32'h104, 1'b1, 1'b0}) begin n_fail++; $display("FAIL flush2 got pc=%h fl=%b tk=%b exp pc=104 fl=1 tk=0", pc_o, flush_o, taken_o); end
    idle();
    n_checks++; if ({pc_o, flush_o} !== {32'h108, 1'b0}) begin n_fail++; $display("FAIL flush_end got pc=%h fl=%b exp pc=108 fl=0", pc_o, flush_o); end
  endtask

  task automatic test_not_taken();
    step(1'b0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 32'h200);
    n_checks++; if ({pc_o, taken_o} !== {32'h10C, 1'b0}) begin n_fail++; $display("FAIL bge_pc got pc=%h tk=%b exp pc=10c tk=0", pc_o, taken_o); end
    n_checks++; if ({br_cnt_o, taken_cnt_o} !== {16'd2, 16'd1}) begin n_fail++; $display("FAIL bge_cnts got=%0d/%0d exp=2/1", br_cnt_o, taken_cnt_o); end
    funct3_i = 3'b110; #1;
    n_checks++; if (br_unsign_o !== 1'b1) begin n_fail++; $display("FAIL unsign_110 got=%b exp=1", br_unsign_o); end
    funct3_i = 3'b100; #1;
    n_checks++; if (br_unsign_o !== 1'b0) begin n_fail++; $display("FAIL unsign_100 got=%b exp=0", br_unsign_o); end
  endtask

  task automatic test_decode();
    logic [3:0] v;
    logic       lt, eq, exp_tk;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      lt = 1'($urandom_range(0, 1));
      eq = 1'($urandom_range(0, 1));
      case (v[2:0])
        3'b000: exp_tk = eq;
        3'b001: exp_tk = !eq;
        3'b100, 3'b110: exp_tk = lt;
        3'b101, 3'b111: exp_tk = !lt;
        default: exp_tk = 1'b0;
      endcase
      step(1'b0, 1'b1, 1'b0, v[2:0], lt, eq, 32'h1000 + 32'(i * 64));
      n_checks++; if (taken_o !== exp_tk) begin n_fail++; $display("FAIL decode f3=%b lt=%b eq=%b got=%b exp=%b", v[2:0], lt, eq, taken_o, exp_tk); end
      while (m_fl) idle();
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    p0 = m_pc;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h300);
      n_checks++; if ({pc_o, taken_o, flush_o} !== {p0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL stall%0d got pc=%h tk=%b fl=%b exp pc=%h tk=0 fl=0", i, pc_o, taken_o, flush_o, p0); end
    end
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h300);
    n_checks++; if ({pc_o, taken_o} !== {32'h300, 1'b1}) begin n_fail++; $display("FAIL stall_release got pc=%h tk=%b exp pc=300 tk=1", pc_o, taken_o); end
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    n_checks++; if ({pc_o, flush_o, taken_o} !== {32'h300, 1'b1, 1'b0}) begin n_fail++; $display("FAIL stall_in_flush got pc=%h fl=%b tk=%b exp pc=300 fl=1 tk=0", pc_o, flush_o, taken_o); end
    idle(); idle();
  endtask

  task automatic test_flush_ignore();
    logic [15:0] bc;
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h400);
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h800);
    n_checks++; if ({pc_o, taken_o} !== {32'h404, 1'b0}) begin n_fail++; $display("FAIL jump_in_flush got pc=%h tk=%b exp pc=404 tk=0", pc_o, taken_o); end
    idle();
    bc = m_brc;
    step(1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 32'h900);
    n_checks++; if ({illegal_o, taken_o, pc_o} !== {1'b1, 1'b0, 32'h40C}) begin n_fail++; $display("FAIL illegal got il=%b tk=%b pc=%h exp il=1 tk=0 pc=40c", illegal_o, taken_o, pc_o); end
    n_checks++; if (br_cnt_o !== bc) begin n_fail++; $display("FAIL illegal_cnt got=%0d exp=%0d", br_cnt_o, bc); end
    idle();
    n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse got=%b exp=0", illegal_o); end
  endtask

  task automatic test_jump_and_branch();
    logic [15:0] bc;
    bc = m_brc;
    step(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 32'hA00);
    n_checks++; if ({pc_o, taken_o} !== {32'hA00, 1'b1}) begin n_fail++; $display("FAIL jump_wins got pc=%h tk=%b exp pc=a00 tk=1", pc_o, taken_o); end
    n_checks++; if (br_cnt_o !== bc + 16'd1) begin n_fail++; $display("FAIL jump_br_cnt got=%0d exp=%0d", br_cnt_o, bc + 16'd1); end
    idle(); idle();
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF2);
    n_checks++; if (pc_o !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL align got=%h exp=fffffff0", pc_o); end
    idle(); idle(); idle(); idle();
    n_checks++; if ({pc_o, flush_o} !== {32'h0, 1'b0}) begin n_fail++; $display("FAIL wrap got pc=%h fl=%b exp pc=0 fl=0", pc_o, flush_o); end
  endtask

  task automatic test_reset_mid_flush();
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h600);
    model_reset();
    #1;
    n_checks++; if ({pc_o, flush_o, taken_o} !== {RESET_PC, 1'b0, 1'b0}) begin n_fail++; $display("FAIL async_rst got pc=%h fl=%b tk=%b exp pc=%h fl=0 tk=0", pc_o, flush_o, taken_o, RESET_PC); end
    n_checks++; if ({br_cnt_o, taken_cnt_o} !== 32'h0) begin n_fail++; $display("FAIL async_rst_cnts got=%h exp=0", {br_cnt_o, taken_cnt_o}); end
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    n_checks++; if ({pc_o, flush_o} !== {RESET_PC, 1'b0}) begin n_fail++; $display("FAIL post_rst got pc=%h fl=%b exp pc=%h fl=0", pc_o, flush_o, RESET_PC); end
    idle();
    n_checks++; if ({pc_o, flush_o} !== {RESET_PC + 32'd4, 1'b0}) begin n_fail++; $display("FAIL post_rst_adv got pc=%h fl=%b exp pc=%h fl=0", pc_o, flush_o, RESET_PC + 32'd4); end
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_taken_branch();
    test_not_taken();
    test_decode();
    test_stall();
    test_flush_ignore();
    test_jump_and_branch();
    test_wrap();
    test_reset_mid_flush();
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
